// File: rtl/brightness_stream_if.sv
// Bundle of the run handshake, source-RAM read port and result-RAM write port
// seen by the brightness sequencer.
interface brightness_stream_if #(
   parameter int DW = 8,
   parameter int AW = 6
);
   logic                 start;
   logic signed [DW:0]   offset;
   logic [AW-1:0]        rd_addr;
   logic [DW-1:0]        rd_data;
   logic [AW-1:0]        wr_addr;
   logic [DW-1:0]        wr_data;
   logic                 wr_en;
   logic                 busy;
   logic                 done;
   logic [AW:0]          pix_count;

   modport master (
      input  start, offset, rd_data,
      output rd_addr, wr_addr, wr_data, wr_en, busy, done, pix_count
   );

   modport slave (
      output start, offset, rd_data,
      input  rd_addr, wr_addr, wr_data, wr_en, busy, done, pix_count
   );
endinterface

// File: rtl/brightness_stream.sv
// Walks the source pixel RAM once per run, adds a latched signed brightness
// offset with saturation, and writes each result to the result RAM.
module brightness_stream #(
   parameter int DW     = 8,
   parameter int AW     = 6,
   parameter int NPIX   = 64,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   brightness_stream_if.master  bus
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t               state, state_nxt;
   logic signed [DW:0]   offset_q;
   logic [AW-1:0]        rd_addr;
   logic                 last_addr;
   logic [RD_LAT-1:0]    vld_p0;
   logic [AW-1:0]        addr_p0 [RD_LAT];
   logic [AW-1:0]        wr_addr;
   logic [DW-1:0]        wr_data;
   logic                 wr_en;
   logic [AW:0]          pix_count;
   logic                 busy;
   logic                 done;

   // Unsigned pixel plus signed offset, clamped to the pixel range.
   function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] pix,
                                             input logic signed [DW:0] off);
      logic signed [DW+1:0] sum;
      sum = $signed({2'b00, pix}) + $signed({off[DW], off});
      if (sum[DW+1])
         return '0;
      else if (sum[DW])
         return '1;
      else
         return sum[DW-1:0];
   endfunction

   // Terminate on the final address rather than counter overflow, so NPIX=2^AW works.
   assign last_addr = (rd_addr == AW'(NPIX - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:  if (bus.start) state_nxt = READ;
         READ: begin
            busy = 1'b1;
            if (last_addr) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (wr_en && !(|vld_p0)) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address issue, valid tags and result write stage.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_addr   <= '0;
         offset_q  <= '0;
         vld_p0    <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         pix_count <= '0;
      end else begin
         if (state == IDLE && bus.start) begin
            rd_addr   <= '0;
            offset_q  <= bus.offset;
            pix_count <= '0;
         end else begin
            if (state == READ && !last_addr)
               rd_addr <= rd_addr + 1'b1;
            if (wr_en)
               pix_count <= pix_count + 1'b1;
         end

         vld_p0[0] <= (state == READ);
         for (int i = 1; i < RD_LAT; i++)
            vld_p0[i] <= vld_p0[i-1];

         wr_en <= vld_p0[RD_LAT-1];
         if (vld_p0[RD_LAT-1]) begin
            wr_addr <= addr_p0[RD_LAT-1];
            wr_data <= sat_add(bus.rd_data, offset_q);
         end
      end
   end

   // Address tags travel alongside the valid bits; they need no reset.
   always_ff @(posedge clk) begin
      addr_p0[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++)
         addr_p0[i] <= addr_p0[i-1];
   end

   assign bus.rd_addr   = rd_addr;
   assign bus.wr_addr   = wr_addr;
   assign bus.wr_data   = wr_data;
   assign bus.wr_en     = wr_en;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.pix_count = pix_count;

endmodule

// File: tb/tb_brightness_stream.sv
// Bench for brightness_stream: a default instance and a short, deeper-latency
// instance sharing one source RAM image, checked cycle by cycle.
module tb_brightness_stream;
   localparam int DW = 8;
   localparam int AW = 6;

   logic clk = 1'b0;
   logic resetn;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   brightness_stream_if #(.DW(DW), .AW(AW)) b0 ();
   brightness_stream_if #(.DW(DW), .AW(AW)) b1 ();

   brightness_stream #(.DW(DW), .AW(AW), .NPIX(64), .RD_LAT(1)) u_dut (
      .clk(clk), .resetn(resetn), .bus(b0.master));
   brightness_stream #(.DW(DW), .AW(AW), .NPIX(5), .RD_LAT(2)) u_sweep (
      .clk(clk), .resetn(resetn), .bus(b1.master));

   // Source RAM image with one- and two-cycle read ports.
   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rd1_stage;
   always @(posedge clk) begin
      b0.rd_data <= mem[b0.rd_addr];
      rd1_stage  <= mem[b1.rd_addr];
      b1.rd_data <= rd1_stage;
   end

   logic          s_wen, s_busy, s_done;
   logic [AW-1:0] s_raddr, s_waddr;
   logic [DW-1:0] s_wdata;
   logic [AW:0]   s_pc;

   function automatic int ref_pix(input int p, input int o);
      int s;
      s = p + o;
      if (s < 0) return 0;
      if (s > 255) return 255;
      return s;
   endfunction

   task automatic sample(input int sel);
      if (sel == 0) begin
         s_wen = b0.wr_en; s_busy = b0.busy; s_done = b0.done; s_raddr = b0.rd_addr;
         s_waddr = b0.wr_addr; s_wdata = b0.wr_data; s_pc = b0.pix_count;
      end else begin
         s_wen = b1.wr_en; s_busy = b1.busy; s_done = b1.done; s_raddr = b1.rd_addr;
         s_waddr = b1.wr_addr; s_wdata = b1.wr_data; s_pc = b1.pix_count;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic st, input int off);
      if (sel == 0) begin b0.start = st; b0.offset = 9'(off); end
      else          begin b1.start = st; b1.offset = 9'(off); end
   endtask

   task automatic chk_all_zero(input int sel, input string tag);
      sample(sel);
      chk({tag, "_rd_addr"}, 32'(s_raddr), 0);
      chk({tag, "_wr_addr"}, 32'(s_waddr), 0);
      chk({tag, "_wr_data"}, 32'(s_wdata), 0);
      chk({tag, "_wr_en"}, 32'(s_wen), 0);
      chk({tag, "_busy"}, 32'(s_busy), 0);
      chk({tag, "_done"}, 32'(s_done), 0);
      chk({tag, "_pix_count"}, 32'(s_pc), 0);
   endtask

   // One run from the start edge: every cycle is compared against the timing
   // and results the reference derives from the RAM image and offset.
   task automatic run(input int sel, input int off, input int npix, input int lat,
                      input int disturb_k, input int abort_k);
      int exp_q [$];
      int last_w, done_k, a;
      logic in_win;
      for (int i = 0; i < npix; i++) exp_q.push_back(ref_pix(int'(mem[i]), off));
      last_w = npix + lat + 1;
      done_k = npix + lat + 2;
      @(negedge clk);
      drive(sel, 1'b1, off);
      @(posedge clk);
      #1 drive(sel, 1'b0, int'($urandom_range(0, 511)) - 256);
      for (int k = 1; k <= done_k; k++) begin
         @(negedge clk);
         if (k == abort_k) begin
            resetn = 1'b0;
            #1 chk_all_zero(sel, "midrst");
            @(negedge clk);
            resetn = 1'b1;
            for (int j = 0; j < 8; j++) begin
               @(negedge clk);
               sample(sel);
               chk("post_rst_wr_en", 32'(s_wen), 0);
               chk("post_rst_done", 32'(s_done), 0);
            end
            return;
         end
         sample(sel);
         in_win = (k >= lat + 2) && (k <= last_w);
         a = k - lat - 2;
         chk("wr_en", 32'(s_wen), 32'(in_win));
         if (in_win) begin
            chk("wr_addr", 32'(s_waddr), a);
            chk("wr_data", 32'(s_wdata), exp_q[a]);
         end
         chk("busy", 32'(s_busy), 32'(k <= last_w));
         chk("done", 32'(s_done), 32'(k == done_k));
         if (k <= last_w) chk("rd_addr", 32'(s_raddr), (k <= npix) ? k - 1 : npix - 1);
         if (k == done_k) chk("pix_count", 32'(s_pc), npix);
         if (k == disturb_k) drive(sel, 1'b1, -50);
         if (k == disturb_k + 1) drive(sel, 1'b0, -50);
      end
      @(negedge clk);
      sample(sel);
      chk("idle_done", 32'(s_done), 0);
      chk("idle_busy", 32'(s_busy), 0);
      chk("pc_hold", 32'(s_pc), npix);
   endtask

   initial begin
      resetn = 1'b0;
      drive(0, 1'b0, 0);
      drive(1, 1'b0, 0);
      for (int i = 0; i < 2**AW; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      chk_all_zero(0, "reset");
      chk_all_zero(1, "reset_sw");
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // Ramp with +10, saturating at the top addresses.
      for (int i = 0; i < 2**AW; i++) mem[i] = 8'(4 * i);
      run(0, 10, 64, 1, -1, -1);

      // Saturation corners followed by random fill.
      for (int i = 0; i < 2**AW; i++) mem[i] = 8'($urandom);
      mem[0] = 8'd0; mem[1] = 8'd1; mem[2] = 8'd128; mem[3] = 8'd250; mem[4] = 8'd255;
      run(0, 255, 64, 1, -1, -1);
      run(0, -256, 64, 1, -1, -1);
      run(0, 0, 64, 1, -1, -1);

      // Random images and offsets.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 2**AW; i++) mem[i] = 8'($urandom);
         run(0, int'($urandom_range(0, 511)) - 256, 64, 1, -1, -1);
      end

      // Start and offset disturbed mid-run must not affect the run.
      for (int i = 0; i < 2**AW; i++) mem[i] = 8'($urandom);
      run(0, 10, 64, 1, 20, -1);

      // Reset mid-run, then a clean run.
      run(0, 10, 64, 1, -1, 30);
      run(0, int'($urandom_range(0, 511)) - 256, 64, 1, -1, -1);

      // Short run with two-cycle read latency.
      run(1, 10, 5, 2, -1, -1);
      for (int i = 0; i < 5; i++) mem[i] = 8'($urandom);
      run(1, int'($urandom_range(0, 511)) - 256, 5, 2, 3, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
